ls194_shift_ctrl: RTL and testbench

Sequencer that sits directly upstream of the ls74194 universal shift register and drives its control inputs: s, p, sil, sir and clear_n.
- Accepts a single shift/rotate command through a start/busy/done handshake.
- Parallel-loads the operand, then issues the correct number of single-bit shift cycles with the right serial fill bit.
- Reads the shifter's q back, for rotate/arithmetic fill and to report the result.
- Turns the 4-bit shifter into a multi-bit barrel-style operation for the CPU datapath.

---
 rtl/ls194_pkg.sv | 37 +++
 rtl/ls194_shift_ctrl.sv | 108 ++++++++++
 tb/tb_ls194_shift_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ls194_pkg.sv
// Shared op codes, ls74194 mode constants and sequencer state encoding
// for the shift controller that drives a 74194 universal shift register.
package ls194_pkg;

    localparam logic [2:0] OP_LSL  = 3'b000;
    localparam logic [2:0] OP_LSR  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Reserved codes 110/111 fall into the plain-load group with OP_LOAD.
    function automatic logic is_load_op(input logic [2:0] op_v);
        is_load_op = (op_v >= OP_LOAD);
    endfunction

    function automatic logic [1:0] shift_mode(input logic [2:0] op_v);
        case (op_v)
            OP_LSL, OP_ROL:         shift_mode = S_SHL;
            OP_LSR, OP_ROR, OP_ASR: shift_mode = S_SHR;
            default:                shift_mode = S_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/ls194_shift_ctrl.sv
// Sequencer driving an ls74194: loads the operand, then steps it one bit per
// cycle with the correct serial fill until the requested amount is reached.
module ls194_shift_ctrl
    import ls194_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] q,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] p,
    output logic             sil,
    output logic             sir,
    output logic             clear_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state_r;
    logic [2:0]       op_r;
    logic [AMT_W-1:0] cnt_r;
    logic [WIDTH-1:0] data_r;

    // Command sequencing: latch in IDLE, load, count shift cycles, pulse done.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r <= ST_IDLE;
            op_r    <= 3'b000;
            cnt_r   <= {AMT_W{1'b0}};
            data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        cnt_r   <= is_load_op(op) ? {AMT_W{1'b0}} : amount;
                        data_r  <= data_in;
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (cnt_r != {AMT_W{1'b0}}) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    cnt_r <= cnt_r - AMT_W'(1);
                    if (cnt_r == AMT_W'(1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Mode select and serial fill; fill bits follow the live q each shift cycle.
    always_comb begin
        s   = S_HOLD;
        sil = 1'b0;
        sir = 1'b0;
        case (state_r)
            ST_LOAD: begin
                s = S_LOAD;
            end
            ST_SHIFT: begin
                s = shift_mode(op_r);
                case (op_r)
                    OP_ROL:  sil = q[WIDTH-1];
                    OP_ROR:  sir = q[0];
                    OP_ASR:  sir = q[WIDTH-1];
                    default: begin
                        sil = 1'b0;
                        sir = 1'b0;
                    end
                endcase
            end
            default: begin
                s = S_HOLD;
            end
        endcase
    end

    assign p       = data_r;
    assign result  = q;
    assign clear_n = ~clear;
    assign busy    = (state_r == ST_LOAD) || (state_r == ST_SHIFT);
    assign done    = (state_r == ST_DONE);

endmodule

// File: tb/tb_ls194_shift_ctrl.sv
// Scoreboard bench for ls194_shift_ctrl with a behavioural 74194 closing the
// q feedback loop.
module tb_ls194_shift_ctrl;

    logic       clk;
    logic       clear;
    logic       start;
    logic [2:0] op;
    logic [2:0] amount;
    logic [3:0] data_in;
    logic [3:0] q;
    logic [1:0] s;
    logic [3:0] p;
    logic       sil;
    logic       sir;
    logic       clear_n;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int n_cmp;
    int n_err;
    int done_cnt;

    typedef struct {
        string      tag;
        logic [3:0] exp_q;
        int         exp_lat;
    } sb_t;

    sb_t sb_q[$];

    ls194_shift_ctrl #(.WIDTH(4), .AMT_W(3)) dut (
        .clk     (clk),
        .clear   (clear),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .data_in (data_in),
        .q       (q),
        .s       (s),
        .p       (p),
        .sil     (sil),
        .sir     (sir),
        .clear_n (clear_n),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74194 model: clear, hold, shift right, shift left, parallel load
    always @(posedge clk) begin
        if (!clear_n) q <= 4'b0000;
        else begin
            case (s)
                2'b01:   q <= {sir, q[3:1]};
                2'b10:   q <= {q[2:0], sil};
                2'b11:   q <= p;
                default: q <= q;
            endcase
        end
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command; optionally pulse start again at wait-cycle poke_k.
    task automatic run_cmd(input string tag, input logic [2:0] o, input logic [2:0] a,
                           input logic [3:0] d, input logic [3:0] exp_q, input int poke_k);
        sb_t        ent;
        sb_t        got;
        logic [1:0] mode;
        int         eff;
        int         k;
        bit         seen;
        eff  = (o >= 3'd5) ? 0 : int'(a);
        mode = (o == 3'd0 || o == 3'd2) ? 2'b10 : 2'b01;
        ent.tag = tag; ent.exp_q = exp_q; ent.exp_lat = 2 + eff;
        @(negedge clk);
        start = 1'b1; op = o; amount = a; data_in = d;
        sb_q.push_back(ent);
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == poke_k) begin
                start = 1'b1; op = 3'd3; amount = 3'd7; data_in = 4'b1111;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check_eq({tag, "_s"}, 32'(s), (k == 1) ? 32'h3 : 32'(mode));
            check_eq({tag, "_busy"}, 32'(busy), 32'h1);
        end
        start = 1'b0;
        if (!seen) begin
            check_eq({tag, "_timeout"}, 32'h0, 32'h1);
            void'(sb_q.pop_front());
        end else begin
            got = sb_q.pop_front();
            check_eq({got.tag, "_lat"}, 32'(k), 32'(got.exp_lat));
            check_eq({got.tag, "_q"}, 32'(result), 32'(got.exp_q));
            check_eq({got.tag, "_s_done"}, 32'(s), 32'h0);
            check_eq({got.tag, "_busy_done"}, 32'(busy), 32'h0);
        end
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'h0);
        check_eq({tag, "_q_hold"}, 32'(q), 32'(exp_q));
    endtask

    initial begin
        int dc0;
        n_cmp = 0; n_err = 0; done_cnt = 0;
        clear = 1'b1; start = 1'b0; op = 3'd0; amount = 3'd0; data_in = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_s", 32'(s), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_clear_n", 32'(clear_n), 32'h0);
        check_eq("rst_q", 32'(q), 32'h0);
        check_eq("rst_p", 32'(p), 32'h0);
        check_eq("rst_sil_sir", 32'({sil, sir}), 32'h0);
        clear = 1'b0;
        #1;
        check_eq("rel_clear_n", 32'(clear_n), 32'h1);

        run_cmd("lsl", 3'd0, 3'd2, 4'b0011, 4'b1100, 0);
        run_cmd("ror", 3'd3, 3'd1, 4'b1001, 4'b1100, 0);
        run_cmd("rol", 3'd2, 3'd3, 4'b1001, 4'b1100, 0);
        run_cmd("asr", 3'd4, 3'd2, 4'b1000, 4'b1110, 0);
        run_cmd("asr_neg", 3'd4, 3'd1, 4'b1011, 4'b1101, 0);
        run_cmd("lsr0", 3'd1, 3'd0, 4'b1010, 4'b1010, 0);
        run_cmd("lsr_max", 3'd1, 3'd7, 4'b1111, 4'b0000, 0);
        run_cmd("rol_max", 3'd2, 3'd7, 4'b1001, 4'b1100, 0);
        run_cmd("ror4", 3'd3, 3'd4, 4'b1011, 4'b1011, 0);
        run_cmd("load", 3'd5, 3'd3, 4'b0101, 4'b0101, 0);
        run_cmd("rsvd", 3'd6, 3'd5, 4'b0110, 4'b0110, 0);

        dc0 = done_cnt;
        run_cmd("poke", 3'd0, 3'd3, 4'b0001, 4'b1000, 3);
        repeat (4) @(negedge clk);
        check_eq("poke_one_done", 32'(done_cnt - dc0), 32'h1);
        check_eq("poke_idle", 32'(busy), 32'h0);

        // clear in the middle of a shift
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 3'd0; amount = 3'd5; data_in = 4'b0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("clr_in_shift", 32'(s), 32'h2);
        clear = 1'b1;
        #1;
        check_eq("clr_clear_n", 32'(clear_n), 32'h0);
        @(negedge clk);
        check_eq("clr_busy", 32'(busy), 32'h0);
        check_eq("clr_q", 32'(q), 32'h0);
        check_eq("clr_p", 32'(p), 32'h0);
        check_eq("clr_s", 32'(s), 32'h0);
        clear = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("clr_no_done", 32'(done_cnt - dc0), 32'h0);
        check_eq("clr_stay_idle", 32'(busy), 32'h0);
        check_eq("clr_q_after", 32'(q), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
